multicycle_pc_sequencer: RTL and testbench
==========================================

# multicycle_pc_sequencer

Control FSM that sequences the multicycle RISC-V datapath through fetch, decode, execute, memory and writeback, and owns the program counter. It replaces free-running PC increment with PC updates gated on instruction retirement, and adds taken-branch/jump redirection and halt. It sits between the decoder/branch unit and the instruction/data memory, register file and instruction register.

## Interface
- ADDR_WIDTH, 7, width of the word-addressed program counter
- CNT_WIDTH, 16, width of the retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_ready  in  1  memory handshake complete this cycle
- op_class  in  2  decoder class, valid in DECODE: 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH/JUMP
- branch_taken  in  1  branch unit decision, valid in EXECUTE
- branch_target  in  ADDR_WIDTH  redirect address, valid in EXECUTE
- halt_req  in  1  stop after the current instruction retires
- pc  out  ADDR_WIDTH  current instruction address
- mem_req  out  1  memory access request
- mem_we  out  1  store write enable
- ir_write  out  1  latch fetched instruction
- reg_write  out  1  register file write enable
- state  out  3  current FSM state encoding
- halted  out  1  FSM in HALT
- retired  out  CNT_WIDTH  count of retired instructions

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5; codes 6/7 go to FETCH next cycle with all outputs 0.
- FETCH: mem_req=1, mem_we=0; stays until mem_ready; in the mem_ready cycle ir_write=1 and next state DECODE.
- DECODE: one cycle; op_class registered internally; later op_class changes ignored until the next DECODE.
- EXECUTE: class ALU -> WRITEBACK; LOAD/STORE -> MEMORY; BRANCH -> retire: pc <= branch_taken ? branch_target : pc+1.
- MEMORY: mem_req=1, mem_we=1 only for STORE; waits for mem_ready; LOAD -> WRITEBACK; STORE -> retire with pc <= pc+1.
- WRITEBACK: reg_write=1 for exactly one cycle; retire with pc <= pc+1.
- Retire: pc updated, retired incremented, next state FETCH, or HALT if halt_req=1 in the retire cycle.
- HALT: all strobes 0, halted=1, pc and retired frozen; left only by reset.
- pc+1 and branch_target wrap modulo 2^ADDR_WIDTH; retired saturates at all-ones.
- mem_req, mem_we, reg_write, halted are decoded from state only; ir_write is the only output that depends on an input (FETCH and mem_ready).

## Timing
- Reset: state=FETCH, pc=0, retired=0, mem_req=1 in the first cycle after reset deassertion; all other outputs 0 during reset.
- Reset mid-operation, including an outstanding mem_req, aborts the instruction with no pc/retired update.
- With mem_ready tied high: ALU 4 cycles, LOAD 5, STORE 4, BRANCH/JUMP 3 cycles from FETCH entry to the next FETCH.
- Each mem_ready-low cycle in FETCH or MEMORY adds one cycle; mem_ready outside FETCH/MEMORY is ignored.
- New pc is visible the cycle after the retire edge, which is the first FETCH cycle of the next instruction.
- halt_req outside the retire cycle is ignored; reset and halt_req together: reset wins.

## Test plan
- Reset, mem_ready=1, 3 ALU instructions -> pc 0,1,2,3 at each FETCH entry, 4 cycles each, reg_write one pulse per instruction, retired=3.
- LOAD with mem_ready low 2 cycles in FETCH and 1 in MEMORY -> 8-cycle instruction, ir_write single pulse, mem_we=0 throughout, pc 0->1.
- STORE -> mem_we=1 only in MEMORY, reg_write never asserted, pc+1.
- BRANCH taken to 0x05 from pc=0x02, then not-taken from 0x05 -> pc 0x05 then 0x06, 3 cycles each.
- pc=0x7F, ALU retires -> pc wraps to 0x00; branch_target 0x7F taken -> pc 0x7F.
- halt_req pulsed in DECODE -> ignored; held through WRITEBACK -> pc+1, retired+1, state=HALT, halted=1, mem_req=0; reset then returns pc=0, state=FETCH.

Source files
------------

// File: rtl/multicycle_pc_sequencer.sv
// multicycle_pc_sequencer: fetch/decode/execute/memory/writeback control FSM that owns the PC
// and advances it only when an instruction retires.
module multicycle_pc_sequencer #(
  parameter int ADDR_WIDTH = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_ready,
  input  logic [1:0]            op_class,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt_req,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired
);
  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
  localparam logic [1:0] OP_ALU    = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_STORE  = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic [1:0]            op_q, op_d;
  logic                  retire;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      retired_q <= '0;
      op_q      <= OP_ALU;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      op_q      <= op_d;
    end
  end
  // Retirement is the only point where pc, the counter and the halt decision move.
  always_comb begin
    retire = (state_q == S_EXECUTE && op_q == OP_BRANCH) ||
             (state_q == S_MEMORY && mem_ready && op_q == OP_STORE) ||
             state_q == S_WRITEBACK;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = op_q == OP_ALU ? S_WRITEBACK : op_q == OP_BRANCH ? S_FETCH : S_MEMORY;
      S_MEMORY:    state_d = !mem_ready ? S_MEMORY : op_q == OP_LOAD ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
    if (retire && halt_req) state_d = S_HALT;
    op_d      = state_q == S_DECODE ? op_class : op_q;
    pc_d      = !retire ? pc_q : (state_q == S_EXECUTE && branch_taken) ? branch_target : pc_q + 1'b1;
    retired_d = (retire && !(&retired_q)) ? retired_q + 1'b1 : retired_q;
  end
  always_comb begin
    mem_req   = state_q == S_FETCH || state_q == S_MEMORY;
    mem_we    = state_q == S_MEMORY && op_q == OP_STORE;
    ir_write  = state_q == S_FETCH && mem_ready && !reset;
    reg_write = state_q == S_WRITEBACK;
    halted    = state_q == S_HALT;
  end
  assign pc      = pc_q;
  assign state   = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_pc_sequencer.sv
// tb_multicycle_pc_sequencer: randomized scenarios checked cycle by cycle against an
// instruction-level model of phases, pc and retired count.
module tb_multicycle_pc_sequencer;
  localparam int AW = 7;
  localparam int CW = 5;
  localparam int VW = 8 + AW + CW;
  logic          clk = 0;
  logic          reset = 1;
  logic          mem_ready = 0;
  logic [1:0]    op_class = 0;
  logic          branch_taken = 0;
  logic [AW-1:0] branch_target = 0;
  logic          halt_req = 0;
  logic [AW-1:0] pc;
  logic          mem_req, mem_we, ir_write, reg_write, halted;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic [AW-1:0] m_pc;
  logic [CW-1:0] m_ret;
  int            n_checks = 0;
  int            n_pass = 0;

  multicycle_pc_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .op_class(op_class),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
    .pc(pc), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .reg_write(reg_write), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1;
    halt_req = 1'($urandom);
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    reset = 0;
    halt_req = 0;
    m_pc = '0;
    m_ret = '0;
  endtask

  // One instruction: phases are laid out from the op class and stall counts,
  // each cycle's outputs compared, then the retirement effect applied to the model.
  task automatic run_instr(input logic [1:0] op, input logic tk, input logic [AW-1:0] tgt,
                           input int fs, input int ms, input logic hr, input int hmode);
    logic [2:0] ph[$];
    logic [VW-1:0] exp_v, got_v;
    logic mr;
    int n;
    ph = {};
    repeat (fs + 1) ph.push_back(3'd0);
    ph.push_back(3'd1);
    ph.push_back(3'd2);
    if (op == 2'd1 || op == 2'd2) repeat (ms + 1) ph.push_back(3'd3);
    if (op == 2'd0 || op == 2'd1) ph.push_back(3'd4);
    n = ph.size();
    for (int c = 0; c < n; c++) begin
      mr = ph[c] == 3'd0 ? (c >= fs) : ph[c] == 3'd3 ? (c >= fs + 3 + ms) : 1'($urandom);
      mem_ready = mr;
      op_class = ph[c] == 3'd1 ? op : 2'($urandom);
      branch_taken = ph[c] == 3'd2 ? tk : 1'($urandom);
      branch_target = ph[c] == 3'd2 ? tgt : AW'($urandom);
      halt_req = c == n - 1 ? hr : hmode == 2 ? 1'b1 : hmode == 1 ? 1'($urandom) :
                 hmode == 3 ? (ph[c] == 3'd1) : 1'b0;
      @(negedge clk);
      exp_v = {ph[c], ph[c] == 3'd0 || ph[c] == 3'd3, ph[c] == 3'd3 && op == 2'd2,
               ph[c] == 3'd0 && mr, ph[c] == 3'd4, 1'b0, m_pc, m_ret};
      got_v = {state, mem_req, mem_we, ir_write, reg_write, halted, pc, retired};
      n_checks++;
      if (got_v !== exp_v)
        $display("FAIL cycle op=%0d c=%0d: got st=%0d req=%b we=%b irw=%b rw=%b h=%b pc=%h ret=%0d, want st=%0d req=%b we=%b irw=%b rw=%b h=%b pc=%h ret=%0d",
                 op, c, got_v[VW-1-:3], got_v[VW-4], got_v[VW-5], got_v[VW-6], got_v[VW-7], got_v[VW-8],
                 got_v[AW+CW-1:CW], got_v[CW-1:0], exp_v[VW-1-:3], exp_v[VW-4], exp_v[VW-5],
                 exp_v[VW-6], exp_v[VW-7], exp_v[VW-8], exp_v[AW+CW-1:CW], exp_v[CW-1:0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    m_pc = (op == 2'd3 && tk) ? tgt : m_pc + 1'b1;
    if (m_ret != {CW{1'b1}}) m_ret = m_ret + 1'b1;
    n_checks++;
    if ({state, halted, pc, retired} !== {hr ? 3'd5 : 3'd0, hr, m_pc, m_ret})
      $display("FAIL retire op=%0d: got st=%0d h=%b pc=%h ret=%0d, want st=%0d h=%b pc=%h ret=%0d",
               op, state, halted, pc, retired, hr ? 3'd5 : 3'd0, hr, m_pc, m_ret);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1;
    halt_req = 1;
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      op_class = 2'($urandom);
      branch_taken = 1'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({state, pc, retired, mem_we, reg_write, ir_write, halted} !== {3'd0, AW'(0), CW'(0), 4'b0})
        $display("FAIL reset_hold: got st=%0d pc=%h ret=%0d we=%b rw=%b irw=%b h=%b, want all zero",
                 state, pc, retired, mem_we, reg_write, ir_write, halted);
      else n_pass++;
    end
    @(posedge clk); #1;
    reset = 0;
    halt_req = 0;
    mem_ready = 0;
    @(negedge clk);
    n_checks++;
    if ({state, mem_req, ir_write, pc, retired} !== {3'd0, 1'b1, 1'b0, AW'(0), CW'(0)})
      $display("FAIL reset_release: got st=%0d req=%b irw=%b pc=%h ret=%0d, want st=0 req=1 irw=0 pc=0 ret=0",
               state, mem_req, ir_write, pc, retired);
    else n_pass++;
    @(posedge clk); #1;
    m_pc = '0;
    m_ret = '0;
  endtask

  task automatic test_alu();
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(2'd0, 1'b0, '0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_load_stall();
    do_reset();
    run_instr(2'd1, 1'b1, 7'h33, 2, 1, 1'b0, 0);
  endtask

  task automatic test_store();
    do_reset();
    run_instr(2'd2, 1'b1, 7'h44, 0, 0, 1'b0, 0);
    run_instr(2'd2, 1'b0, 7'h12, 1, 2, 1'b0, 0);
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(2'd0, 1'b0, '0, 0, 0, 1'b0, 0);
    run_instr(2'd0, 1'b0, '0, 0, 0, 1'b0, 0);
    run_instr(2'd3, 1'b1, 7'h05, 0, 0, 1'b0, 0);
    run_instr(2'd3, 1'b0, 7'h40, 0, 0, 1'b0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(2'd3, 1'b1, 7'h7F, 0, 0, 1'b0, 0);
    run_instr(2'd0, 1'b0, '0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 45; i++)
      run_instr(2'($urandom), 1'($urandom), AW'($urandom), $urandom_range(2, 0),
                $urandom_range(2, 0), 1'b0, 1);
  endtask

  task automatic test_halt();
    do_reset();
    run_instr(2'd0, 1'b0, '0, 0, 0, 1'b0, 3);
    run_instr(2'd0, 1'b0, '0, 1, 0, 1'b1, 2);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom);
      halt_req = 1'($urandom);
      op_class = 2'($urandom);
      branch_taken = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ({state, halted, mem_req, mem_we, ir_write, reg_write, pc, retired} !==
          {3'd5, 1'b1, 4'b0, m_pc, m_ret})
        $display("FAIL halt_frozen: got st=%0d h=%b req=%b we=%b irw=%b rw=%b pc=%h ret=%0d, want st=5 h=1 strobes=0 pc=%h ret=%0d",
                 state, halted, mem_req, mem_we, ir_write, reg_write, pc, retired, m_pc, m_ret);
      else n_pass++;
      @(posedge clk); #1;
    end
    reset = 1;
    halt_req = 1;
    @(posedge clk); #1;
    reset = 0;
    mem_ready = 0;
    @(negedge clk);
    n_checks++;
    if ({state, halted, pc, retired} !== {3'd0, 1'b0, AW'(0), CW'(0)})
      $display("FAIL halt_reset: got st=%0d h=%b pc=%h ret=%0d, want st=0 h=0 pc=0 ret=0",
               state, halted, pc, retired);
    else n_pass++;
    halt_req = 0;
    @(posedge clk); #1;
    m_pc = '0;
    m_ret = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr(2'd0, 1'b0, '0, 0, 0, 1'b0, 0);
    run_instr(2'd3, 1'b1, 7'h2A, 0, 0, 1'b0, 0);
    mem_ready = 0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++;
    if ({state, mem_req, pc} !== {3'd0, 1'b1, 7'h2A})
      $display("FAIL stall_fetch: got st=%0d req=%b pc=%h, want st=0 req=1 pc=2a", state, mem_req, pc);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1;
    mem_ready = 1;
    @(posedge clk); #1;
    reset = 0;
    mem_ready = 0;
    @(negedge clk);
    n_checks++;
    if ({state, pc, retired} !== {3'd0, AW'(0), CW'(0)})
      $display("FAIL reset_mid: got st=%0d pc=%h ret=%0d, want st=0 pc=0 ret=0", state, pc, retired);
    else n_pass++;
    @(posedge clk); #1;
    m_pc = '0;
    m_ret = '0;
    run_instr(2'd1, 1'b0, '0, 0, 1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_stall();
    test_store();
    test_branch();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
